// File: rtl/m2_ebi_if_handshake.sv
// M2-side EBI endpoint: unpacks M1->M2 entries into L2 handshakes and packs L2
// responses into M2->M1 entries. Optional R-burst checking: M2_EBI_PROTO_CHECK_EN.
module m2_ebi_if_handshake #(
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned AR_W       = 64,
  parameter int unsigned AW_W       = 64,
  parameter int unsigned W_BEAT_W   = 72,
  parameter int unsigned CR_W       = 8,
  parameter int unsigned CD_BEAT_W  = 64,
  parameter int unsigned R_BEAT_W   = 70,
  parameter int unsigned B_W        = 8,
  parameter int unsigned AC_W       = 48,
  parameter int unsigned M1M2_MSG_W = 288,
  parameter int unsigned M2M1_MSG_W = 280
) (
  input  logic                       m2_clk_i,
  input  logic                       rst_ni,
  input  logic [4:0]                 m1_m2_vc_valid_i,
  input  logic [4:0][M1M2_MSG_W-1:0] m1_m2_vc_entry_list_i,
  output logic [4:0]                 m1_m2_entry_recv_success_o,
  output logic [2:0]                 m2_m1_channel_entry_valid_o,
  input  logic [2:0]                 m2_m1_channel_push_ready_i,
  output logic [2:0][M2M1_MSG_W-1:0] m2_m1_channel_hs_entry_o,
  output logic                       ar_valid_o,
  input  logic                       ar_ready_i,
  output logic [AR_W-1:0]            ar_o,
  output logic                       aw_valid_o,
  input  logic                       aw_ready_i,
  output logic [AW_W-1:0]            aw_o,
  output logic                       w_valid_o,
  input  logic                       w_ready_i,
  output logic [W_BEAT_W-1:0]        w_o,
  output logic                       w_last_o,
  output logic                       cr_valid_o,
  input  logic                       cr_ready_i,
  output logic [CR_W-1:0]            cr_o,
  output logic                       cd_valid_o,
  input  logic                       cd_ready_i,
  output logic [CD_BEAT_W-1:0]       cd_o,
  output logic                       cd_last_o,
  input  logic                       r_valid_i,
  output logic                       r_ready_o,
  input  logic [R_BEAT_W-1:0]        r_i,
  input  logic                       r_last_i,
  input  logic                       b_valid_i,
  output logic                       b_ready_o,
  input  logic [B_W-1:0]             b_i,
  input  logic                       ac_valid_i,
  output logic                       ac_ready_o,
  input  logic [AC_W-1:0]            ac_i,
  output logic [1:0]                 proto_err_o
);

  localparam int unsigned CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  // ---------------- M1 -> M2 receive ----------------
  logic [4:0]                 rx_valid_q;
  logic [4:0][M1M2_MSG_W-1:0] rx_entry_q;
  logic [CNT_W-1:0]           w_cnt_q;
  logic [CNT_W-1:0]           cd_cnt_q;
  logic [4:0]                 rx_hs;
  logic [4:0]                 rx_done;

  always_comb begin
    rx_hs[0] = rx_valid_q[0] & ar_ready_i;
    rx_hs[1] = rx_valid_q[1] & aw_ready_i;
    rx_hs[2] = rx_valid_q[2] & w_ready_i;
    rx_hs[3] = rx_valid_q[3] & cr_ready_i;
    rx_hs[4] = rx_valid_q[4] & cd_ready_i;
    rx_done    = rx_hs;
    rx_done[2] = rx_hs[2] & (w_cnt_q == LAST_BEAT);
    rx_done[4] = rx_hs[4] & (cd_cnt_q == LAST_BEAT);
  end

  assign m1_m2_entry_recv_success_o = rx_done;

  always_ff @(posedge m2_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_valid_q <= '0;
      rx_entry_q <= '0;
      w_cnt_q    <= '0;
      cd_cnt_q   <= '0;
    end else begin
      // capture requires an empty holder, so it can never coincide with success
      for (int unsigned i = 0; i < 5; i++) begin
        if (rx_done[i]) begin
          rx_valid_q[i] <= 1'b0;
        end else if (!rx_valid_q[i] && m1_m2_vc_valid_i[i]) begin
          rx_valid_q[i] <= 1'b1;
          rx_entry_q[i] <= m1_m2_vc_entry_list_i[i];
        end
      end
      if (rx_hs[2]) w_cnt_q  <= (w_cnt_q  == LAST_BEAT) ? '0 : w_cnt_q  + 1'b1;
      if (rx_hs[4]) cd_cnt_q <= (cd_cnt_q == LAST_BEAT) ? '0 : cd_cnt_q + 1'b1;
    end
  end

  always_comb begin
    w_o  = '0;
    cd_o = '0;
    for (int unsigned k = 0; k < BURST_LEN; k++) begin
      if (w_cnt_q == CNT_W'(k))  w_o  = rx_entry_q[2][k*W_BEAT_W +: W_BEAT_W];
      if (cd_cnt_q == CNT_W'(k)) cd_o = rx_entry_q[4][k*CD_BEAT_W +: CD_BEAT_W];
    end
  end

  assign ar_valid_o = rx_valid_q[0];
  assign ar_o       = rx_entry_q[0][AR_W-1:0];
  assign aw_valid_o = rx_valid_q[1];
  assign aw_o       = rx_entry_q[1][AW_W-1:0];
  assign w_valid_o  = rx_valid_q[2];
  assign w_last_o   = (w_cnt_q == LAST_BEAT);
  assign cr_valid_o = rx_valid_q[3];
  assign cr_o       = rx_entry_q[3][CR_W-1:0];
  assign cd_valid_o = rx_valid_q[4];
  assign cd_last_o  = (cd_cnt_q == LAST_BEAT);

  // ---------------- M2 -> M1 pack ----------------
  logic [2:0]                 tx_valid_q;
  logic [2:0][M2M1_MSG_W-1:0] tx_entry_q;
  logic [CNT_W-1:0]           r_cnt_q;
  logic                       r_hs;
  logic                       r_done;
  logic                       b_hs;
  logic                       ac_hs;

  assign r_ready_o  = ~tx_valid_q[0];
  assign b_ready_o  = ~tx_valid_q[1];
  assign ac_ready_o = ~tx_valid_q[2];
  assign r_hs   = r_valid_i & ~tx_valid_q[0];
  assign r_done = r_hs & (r_last_i | (r_cnt_q == LAST_BEAT));
  assign b_hs   = b_valid_i & ~tx_valid_q[1];
  assign ac_hs  = ac_valid_i & ~tx_valid_q[2];

  always_ff @(posedge m2_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_valid_q <= '0;
      tx_entry_q <= '0;
      r_cnt_q    <= '0;
    end else begin
      // a short burst leaves the unwritten upper beats of the entry stale
      if (r_hs) begin
        for (int unsigned k = 0; k < BURST_LEN; k++) begin
          if (r_cnt_q == CNT_W'(k)) tx_entry_q[0][k*R_BEAT_W +: R_BEAT_W] <= r_i;
        end
        r_cnt_q <= r_done ? '0 : r_cnt_q + 1'b1;
      end
      if (r_done) begin
        tx_valid_q[0] <= 1'b1;
      end else if (tx_valid_q[0] && m2_m1_channel_push_ready_i[0]) begin
        tx_valid_q[0] <= 1'b0;
      end

      if (b_hs) begin
        tx_valid_q[1] <= 1'b1;
        tx_entry_q[1] <= M2M1_MSG_W'(b_i);
      end else if (tx_valid_q[1] && m2_m1_channel_push_ready_i[1]) begin
        tx_valid_q[1] <= 1'b0;
      end

      if (ac_hs) begin
        tx_valid_q[2] <= 1'b1;
        tx_entry_q[2] <= M2M1_MSG_W'(ac_i);
      end else if (tx_valid_q[2] && m2_m1_channel_push_ready_i[2]) begin
        tx_valid_q[2] <= 1'b0;
      end
    end
  end

  assign m2_m1_channel_entry_valid_o = tx_valid_q;
  assign m2_m1_channel_hs_entry_o    = tx_entry_q;

`ifdef M2_EBI_PROTO_CHECK_EN
  logic [1:0] proto_err_q;

  always_ff @(posedge m2_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      proto_err_q <= '0;
    end else if (r_hs) begin
      if (r_last_i && (r_cnt_q != LAST_BEAT))  proto_err_q[0] <= 1'b1;
      if (!r_last_i && (r_cnt_q == LAST_BEAT)) proto_err_q[1] <= 1'b1;
    end
  end

  assign proto_err_o = proto_err_q;
`else
  assign proto_err_o = '0;
`endif

  // upper entry bits beyond each channel's payload are held but never presented
  logic unused_entry_bits;
  assign unused_entry_bits = ^rx_entry_q;

endmodule

// File: tb/tb_m2_ebi_if_handshake.sv
// Randomized scoreboard bench for m2_ebi_if_handshake: sources queue expected
// beats/entries at issue, an independent monitor pops and compares them.
module tb_m2_ebi_if_handshake;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [4:0]         vc_valid;
  logic [4:0][287:0]  vc_entry;
  logic [4:0]         rs;
  logic [2:0]         hv;
  logic [2:0]         pr;
  logic [2:0][279:0]  he;
  logic               ar_valid_o, ar_ready_i;  logic [63:0] ar_o;
  logic               aw_valid_o, aw_ready_i;  logic [63:0] aw_o;
  logic               w_valid_o, w_ready_i, w_last_o;  logic [71:0] w_o;
  logic               cr_valid_o, cr_ready_i;  logic [7:0] cr_o;
  logic               cd_valid_o, cd_ready_i, cd_last_o;  logic [63:0] cd_o;
  logic               r_valid_i, r_ready_o, r_last_i;  logic [69:0] r_i;
  logic               b_valid_i, b_ready_o;  logic [7:0] b_i;
  logic               ac_valid_i, ac_ready_o;  logic [47:0] ac_i;
  logic [1:0]         proto_err;

  always #5 clk = ~clk;

  m2_ebi_if_handshake #(.BURST_LEN(4), .M1M2_MSG_W(288), .M2M1_MSG_W(280)) dut (
    .m2_clk_i(clk), .rst_ni(rst_n),
    .m1_m2_vc_valid_i(vc_valid), .m1_m2_vc_entry_list_i(vc_entry),
    .m1_m2_entry_recv_success_o(rs),
    .m2_m1_channel_entry_valid_o(hv), .m2_m1_channel_push_ready_i(pr),
    .m2_m1_channel_hs_entry_o(he),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_o(ar_o),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_o(aw_o),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_o(w_o), .w_last_o(w_last_o),
    .cr_valid_o(cr_valid_o), .cr_ready_i(cr_ready_i), .cr_o(cr_o),
    .cd_valid_o(cd_valid_o), .cd_ready_i(cd_ready_i), .cd_o(cd_o), .cd_last_o(cd_last_o),
    .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_i(r_i), .r_last_i(r_last_i),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_i(b_i),
    .ac_valid_i(ac_valid_i), .ac_ready_o(ac_ready_o), .ac_i(ac_i),
    .proto_err_o(proto_err)
  );

  typedef struct packed { logic [127:0] d; logic last; } exp_t;

  exp_t         q_ar[$], q_aw[$], q_w[$], q_cr[$], q_cd[$];
  logic [279:0] q_r[$];
  logic [7:0]   q_b[$];
  logic [47:0]  q_ac[$];

  int           checks = 0;
  int           fails  = 0;
  bit           stim_en = 0, gen_en = 0, mon_en = 0;
  logic [287:0] cur_entry [5];
  logic [4:0]   cur_valid;
  logic [1:0]   exp_err;
  logic [69:0]  mb [4];
  int           mcnt;

  task automatic chk(input string name, input logic [279:0] got, input logic [279:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    fails++;
    $display("FAIL %s got=event exp=none", name);
  endtask

  function automatic logic [287:0] rnd288();
    logic [287:0] r;
    for (int k = 0; k < 9; k++) r[k*32 +: 32] = $urandom();
    return r;
  endfunction

  // M1 source: the whole entry is random; only each channel's payload slice is expected
  task automatic new_entry(input int ch);
    logic [287:0] ent;
    exp_t e;
    ent = rnd288();
    cur_entry[ch] = ent;
    cur_valid[ch] = 1'b1;
    case (ch)
      0: begin e.d = 128'(ent[63:0]); e.last = 1'b1; q_ar.push_back(e); end
      1: begin e.d = 128'(ent[63:0]); e.last = 1'b1; q_aw.push_back(e); end
      3: begin e.d = 128'(ent[7:0]);  e.last = 1'b1; q_cr.push_back(e); end
      2: for (int k = 0; k < 4; k++) begin
           e.d = 128'(ent[k*72 +: 72]); e.last = (k == 3); q_w.push_back(e);
         end
      default: for (int k = 0; k < 4; k++) begin
           e.d = 128'(ent[k*64 +: 64]); e.last = (k == 3); q_cd.push_back(e);
         end
    endcase
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [4:0] succ_s;
    logic       r_hs_s, b_hs_s, ac_hs_s, done;
    int         r_len, r_idx, v;
    bit         r_norlast;
    r_len = 0; r_idx = 0; r_norlast = 0;
    forever begin
      @(negedge clk);
      succ_s  = rs;
      r_hs_s  = r_valid_i & r_ready_o;
      b_hs_s  = b_valid_i & b_ready_o;
      ac_hs_s = ac_valid_i & ac_ready_o;
      @(posedge clk);
      #1;
      if (stim_en) begin
        for (int i = 0; i < 5; i++) begin
          if (succ_s[i]) cur_valid[i] = 1'b0;
          if (!cur_valid[i] && gen_en && $urandom_range(0, 2) == 0) new_entry(i);
          vc_entry[i] = cur_entry[i];
        end
        vc_valid   = cur_valid;
        ar_ready_i = 1'($urandom_range(0, 1));
        aw_ready_i = 1'($urandom_range(0, 1));
        w_ready_i  = 1'($urandom_range(0, 1));
        cr_ready_i = 1'($urandom_range(0, 1));
        cd_ready_i = 1'($urandom_range(0, 1));
        pr         = 3'($urandom_range(0, 7));

        // R reference: an entry closes on rlast or on its 4th beat
        if (r_hs_s) begin
          done = r_last_i || (mcnt == 3);
          if (r_last_i && mcnt != 3)  exp_err[0] = 1'b1;
          if (!r_last_i && mcnt == 3) exp_err[1] = 1'b1;
          mb[mcnt] = r_i;
          if (done) begin
            q_r.push_back({mb[3], mb[2], mb[1], mb[0]});
            mcnt = 0;
          end else begin
            mcnt++;
          end
          r_idx++;
          if (r_idx == r_len) begin
            r_valid_i = 1'b0;
          end else begin
            r_i      = rnd288()[69:0];
            r_last_i = !r_norlast && (r_idx == r_len - 1);
          end
        end
        if (!r_valid_i && gen_en && $urandom_range(0, 1) == 0) begin
          v         = $urandom_range(0, 5);
          r_norlast = (v == 1);
          r_len     = (v == 0) ? $urandom_range(1, 3) : 4;
          r_idx     = 0;
          r_valid_i = 1'b1;
          r_i       = rnd288()[69:0];
          r_last_i  = !r_norlast && (r_len == 1);
        end

        if (b_hs_s) b_valid_i = 1'b0;
        if (!b_valid_i && gen_en && $urandom_range(0, 2) == 0) begin
          b_i = 8'($urandom()); b_valid_i = 1'b1; q_b.push_back(b_i);
        end
        if (ac_hs_s) ac_valid_i = 1'b0;
        if (!ac_valid_i && gen_en && $urandom_range(0, 2) == 0) begin
          ac_i = rnd288()[47:0]; ac_valid_i = 1'b1; q_ac.push_back(ac_i);
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    exp_t       e;
    logic [4:0] hs_v;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        hs_v = {cd_valid_o & cd_ready_i, cr_valid_o & cr_ready_i, w_valid_o & w_ready_i,
                aw_valid_o & aw_ready_i, ar_valid_o & ar_ready_i};
        for (int i = 0; i < 5; i++) if (rs[i] && !hs_v[i]) flag("success_without_handshake");
        if (hs_v[0]) begin
          if (q_ar.size() == 0) flag("ar_unexpected");
          else begin e = q_ar.pop_front(); chk("ar_payload", ar_o, e.d); chk("ar_success", rs[0], 1'b1); end
        end
        if (hs_v[1]) begin
          if (q_aw.size() == 0) flag("aw_unexpected");
          else begin e = q_aw.pop_front(); chk("aw_payload", aw_o, e.d); chk("aw_success", rs[1], 1'b1); end
        end
        if (hs_v[2]) begin
          if (q_w.size() == 0) flag("w_unexpected");
          else begin
            e = q_w.pop_front();
            chk("w_beat", w_o, e.d); chk("w_last", w_last_o, e.last); chk("w_success", rs[2], e.last);
          end
        end
        if (hs_v[3]) begin
          if (q_cr.size() == 0) flag("cr_unexpected");
          else begin e = q_cr.pop_front(); chk("cr_payload", cr_o, e.d); chk("cr_success", rs[3], 1'b1); end
        end
        if (hs_v[4]) begin
          if (q_cd.size() == 0) flag("cd_unexpected");
          else begin
            e = q_cd.pop_front();
            chk("cd_beat", cd_o, e.d); chk("cd_last", cd_last_o, e.last); chk("cd_success", rs[4], e.last);
          end
        end
        if (hv[0] && pr[0]) begin
          if (q_r.size() == 0) flag("r_push_unexpected");
          else chk("r_entry", he[0], q_r.pop_front());
        end
        if (hv[1] && pr[1]) begin
          if (q_b.size() == 0) flag("b_push_unexpected");
          else chk("b_entry", he[1][7:0], q_b.pop_front());
        end
        if (hv[2] && pr[2]) begin
          if (q_ac.size() == 0) flag("ac_push_unexpected");
          else chk("ac_entry", he[2][47:0], q_ac.pop_front());
        end
      end
    end
  end

  function automatic bit idle();
    return (cur_valid == '0) && !r_valid_i && !b_valid_i && !ac_valid_i &&
           q_ar.size() == 0 && q_aw.size() == 0 && q_w.size() == 0 && q_cr.size() == 0 &&
           q_cd.size() == 0 && q_r.size() == 0 && q_b.size() == 0 && q_ac.size() == 0;
  endfunction

  // ---------------- control ----------------
  initial begin : main
    logic [287:0] cd_e;
    logic [1:0]   err_req;
    int           n;
    rst_n = 1'b0; vc_valid = '0; vc_entry = '0; pr = '0;
    ar_ready_i = 0; aw_ready_i = 0; w_ready_i = 0; cr_ready_i = 0; cd_ready_i = 0;
    r_valid_i = 0; r_i = '0; r_last_i = 0; b_valid_i = 0; b_i = '0; ac_valid_i = 0; ac_i = '0;
    cur_valid = '0; exp_err = '0; mcnt = 0;
    for (int i = 0; i < 5; i++) cur_entry[i] = '0;
    for (int i = 0; i < 4; i++) mb[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rx_valids", {cd_valid_o, cr_valid_o, w_valid_o, aw_valid_o, ar_valid_o}, 5'b0);
    chk("rst_success", rs, 5'b0);
    chk("rst_tx_valids", hv, 3'b0);
    chk("rst_entries", he, '0);
    chk("rst_readies", {r_ready_o, b_ready_o, ac_ready_o}, 3'b111);
    chk("rst_proto_err", proto_err, 2'b00);
    chk("rst_last_flags", {w_last_o, cd_last_o}, 2'b00);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1; stim_en = 1; gen_en = 1;
    repeat (1500) @(posedge clk);
    gen_en = 0;

    n = 0;
    while (!idle() && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (!idle()) flag("drain_timeout");
    repeat (4) @(posedge clk);
    #1;
    stim_en = 0;
    vc_valid = '0; pr = '0; r_valid_i = 0; b_valid_i = 0; ac_valid_i = 0;
    ar_ready_i = 0; aw_ready_i = 0; w_ready_i = 0; cr_ready_i = 0; cd_ready_i = 0;
    #1;
    chk("drain_tx_valids", hv, 3'b0);
    chk("drain_rx_valids", {cd_valid_o, cr_valid_o, w_valid_o, aw_valid_o, ar_valid_o}, 5'b0);
    chk("drain_readies", {r_ready_o, b_ready_o, ac_ready_o}, 3'b111);
`ifdef M2_EBI_PROTO_CHECK_EN
    err_req = exp_err;
`else
    err_req = 2'b00;
`endif
    chk("proto_err", proto_err, err_req);
    mon_en = 0;

    // reset in the middle of a CD burst, then a fresh burst must start at beat 0
    @(posedge clk);
    #1;
    cd_e = rnd288();
    vc_entry[4] = cd_e; vc_valid = 5'b10000; cd_ready_i = 1'b1;
    @(posedge clk);
    #1;
    vc_valid = '0;
    chk("cd_pre_beat0", cd_o, cd_e[63:0]);
    @(posedge clk);
    #1;
    chk("cd_pre_beat1", cd_o, cd_e[127:64]);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rx_valids", {cd_valid_o, cr_valid_o, w_valid_o, aw_valid_o, ar_valid_o}, 5'b0);
    chk("mid_rst_tx_valids", hv, 3'b0);
    chk("mid_rst_proto_err", proto_err, 2'b00);
    chk("mid_rst_cd_last", cd_last_o, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1; cd_ready_i = 1'b0;
    cd_e = rnd288();
    vc_entry[4] = cd_e; vc_valid = 5'b10000;
    @(posedge clk);
    #1;
    vc_valid = '0;
    chk("cd_fresh_valid", cd_valid_o, 1'b1);
    chk("cd_fresh_hold_success", rs[4], 1'b0);
    for (int k = 0; k < 4; k++) begin
      cd_ready_i = 1'b1;
      #1;
      chk("cd_fresh_beat", cd_o, cd_e[k*64 +: 64]);
      chk("cd_fresh_last", cd_last_o, k == 3);
      chk("cd_fresh_success", rs[4], k == 3);
      @(posedge clk);
      #1;
    end
    cd_ready_i = 1'b0;
    #1;
    chk("cd_fresh_cleared", cd_valid_o, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
